pulse_gen_top: RTL and testbench

- Multi-channel programmable pulse generator; the stimulus-side counterpart of the channel pulse filter.
- Software or a sequencer issues per-channel commands: high width, low gap and repeat count, all in clk cycles.
- Each channel emits exact-width pulse trains on pulse_out. These drive filter inputs (pulse_in) in self-test builds and external pulse lines in normal use.
- 20 MHz clk nominal; 22-bit counts cover up to about 209 ms per phase.

---
 rtl/pulse_gen_top.sv | 145 ++++++++++++++
 tb/tb_pulse_gen_top.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_top.sv
// Multi-channel programmable pulse generator: per-channel high width, low gap and repeat count.
// Define PULSE_GEN_ABORT_EN to add a per-channel abort input that forces a channel back to IDLE.
module pulse_gen_top #(
  parameter int NUM_CH = 32,
  parameter int CNT_W  = 22,
  parameter int REP_W  = 8,
  parameter int CH_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_chan,
  input  logic [CNT_W-1:0]  cmd_width,
  input  logic [CNT_W-1:0]  cmd_gap,
  input  logic [REP_W-1:0]  cmd_count,
`ifdef PULSE_GEN_ABORT_EN
  input  logic [NUM_CH-1:0] abort,
`endif
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  // state | meaning
  // IDLE  | waiting for a command, busy=0
  // HIGH  | driving pulse_out high, cnt counts down the width
  // LOW   | gap between pulses, cnt counts down max(gap,1)
  // FIN   | degenerate command (width or count 0), done next cycle
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] accept;

  // Out-of-range channel numbers select nothing, so cmd_ready stays low for them.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = (32'(cmd_chan) == i);
    end
  end

`ifdef PULSE_GEN_ABORT_EN
  assign cmd_ready = |(sel & ~busy & ~abort);
`else
  assign cmd_ready = |(sel & ~busy);
`endif

  assign accept = sel & {NUM_CH{cmd_valid & cmd_ready}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic [REP_W-1:0] rep;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        width_q <= '0;
        gap_q   <= '0;
        rep     <= '0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end
`ifdef PULSE_GEN_ABORT_EN
      else if (abort[g]) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        rep     <= '0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= busy_q;
      end
`endif
      else begin
        done_q <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (accept[g]) begin
              width_q <= cmd_width;
              gap_q   <= cmd_gap;
              busy_q  <= 1'b1;
              if (cmd_width != '0 && cmd_count != '0) begin
                state   <= ST_HIGH;
                cnt     <= cmd_width;
                rep     <= cmd_count;
                pulse_q <= 1'b1;
              end else begin
                state <= ST_FIN;
              end
            end
          end
          ST_HIGH: begin
            if (cnt == CNT_W'(1)) begin
              pulse_q <= 1'b0;
              if (rep > REP_W'(1)) begin
                rep   <= rep - REP_W'(1);
                cnt   <= (gap_q == '0) ? CNT_W'(1) : gap_q;
                state <= ST_LOW;
              end else begin
                rep    <= '0;
                cnt    <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state  <= ST_IDLE;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_LOW: begin
            if (cnt == CNT_W'(1)) begin
              cnt     <= width_q;
              pulse_q <= 1'b1;
              state   <= ST_HIGH;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_FIN: begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign pulse_out[g] = pulse_q;
    assign busy[g]      = busy_q;
    assign done[g]      = done_q;
  end

endmodule

// File: tb/tb_pulse_gen_top.sv
// Bench for pulse_gen_top: directed and random commands checked against a timeline model
// that computes each channel's outputs from its accept cycle and command fields.
module tb_pulse_gen_top;
  localparam int NUM_CH = 32;
  localparam int CNT_W  = 22;
  localparam int REP_W  = 8;
  localparam int CH_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_chan = '0;
  logic [CNT_W-1:0]  cmd_width = '0;
  logic [CNT_W-1:0]  cmd_gap = '0;
  logic [REP_W-1:0]  cmd_count = '0;
  logic [NUM_CH-1:0] pulse_out;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] ab_req = '0;
`ifdef PULSE_GEN_ABORT_EN
  logic [NUM_CH-1:0] abort = '0;
`endif

  pulse_gen_top #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_width(cmd_width), .cmd_gap(cmd_gap), .cmd_count(cmd_count),
`ifdef PULSE_GEN_ABORT_EN
    .abort(abort),
`endif
    .pulse_out(pulse_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Model: per channel, the edge that accepted the last command, its fields, and abort edge.
  longint st_a [NUM_CH];
  longint st_w [NUM_CH];
  longint st_g [NUM_CH];
  longint st_n [NUM_CH];
  longint ab_c [NUM_CH];
  int pulse_seen [NUM_CH];
  int busy_seen  [NUM_CH];
  int done_seen  [NUM_CH];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic longint total_len(input int ch);
    if (st_w[ch] == 0 || st_n[ch] == 0) return 1;
    return st_n[ch] * st_w[ch] + (st_n[ch] - 1) * ((st_g[ch] == 0) ? 1 : st_g[ch]);
  endfunction

  function automatic void model_at(input int ch, input longint c,
                                   output logic p, output logic b, output logic d);
    longint off;
    longint per;
    p = 1'b0; b = 1'b0; d = 1'b0;
    if (st_a[ch] < 0) return;
    if (ab_c[ch] >= 0 && c >= ab_c[ch]) begin
      d = (c == ab_c[ch]);
      return;
    end
    off = c - st_a[ch];
    if (off < 0) return;
    if (off < total_len(ch)) begin
      b = 1'b1;
      if (st_w[ch] != 0 && st_n[ch] != 0) begin
        per = st_w[ch] + ((st_g[ch] == 0) ? 1 : st_g[ch]);
        p = ((off % per) < st_w[ch]);
      end
    end else if (off == total_len(ch)) begin
      d = 1'b1;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      st_a[i] = -1; ab_c[i] = -1;
    end
  endtask

  task automatic clr_seen();
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_seen[i] = 0; busy_seen[i] = 0; done_seen[i] = 0;
    end
  endtask

  // One cycle: check outputs at the falling edge, then present the next command.
  task automatic step(input logic v, input int ch, input longint w, input longint g,
                      input longint n, output logic acc);
    logic [NUM_CH-1:0] ep, eb, ed;
    logic p, b, d, er;
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      model_at(i, cyc, p, b, d);
      ep[i] = p; eb[i] = b; ed[i] = d;
      if (pulse_out[i]) pulse_seen[i]++;
      if (busy[i]) busy_seen[i]++;
      if (done[i]) done_seen[i]++;
    end
    check_val("pulse_out", 64'(pulse_out), 64'(ep));
    check_val("busy", 64'(busy), 64'(eb));
    check_val("done", 64'(done), 64'(ed));
    cmd_valid = v;
    cmd_chan  = ch[CH_W-1:0];
    cmd_width = w[CNT_W-1:0];
    cmd_gap   = g[CNT_W-1:0];
    cmd_count = n[REP_W-1:0];
`ifdef PULSE_GEN_ABORT_EN
    abort = ab_req;
`endif
    #1;
    er = 1'b0;
    if (ch < NUM_CH) er = !eb[ch] && !ab_req[ch];
    check_val("cmd_ready", 64'(cmd_ready), 64'(er));
    for (int i = 0; i < NUM_CH; i++) begin
      if (ab_req[i] && eb[i]) ab_c[i] = cyc + 1;
    end
    acc = v && er;
    if (acc) begin
      st_a[ch] = cyc + 1; st_w[ch] = w; st_g[ch] = g; st_n[ch] = n; ab_c[ch] = -1;
    end
  endtask

  task automatic idle(input int cycles);
    logic acc;
    repeat (cycles) step(1'b0, 0, 0, 0, 0, acc);
  endtask

  task automatic issue(input int ch, input longint w, input longint g, input longint n);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 3000 && !acc; k++) step(1'b1, ch, w, g, n, acc);
    check_val("issue_accept", 64'(acc), 64'(1));
  endtask

  initial begin
    logic acc;
    int ch;
    model_reset();
    clr_seen();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pulse", 64'(pulse_out), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    clr_seen();
    issue(0, 40, 5, 1);
    idle(45);
    check_val("single_high", 64'(pulse_seen[0]), 64'(40));
    check_val("single_busy", 64'(busy_seen[0]), 64'(40));
    check_val("single_done", 64'(done_seen[0]), 64'(1));

    clr_seen();
    issue(3, 10, 4, 3);
    idle(42);
    check_val("train_high", 64'(pulse_seen[3]), 64'(30));
    check_val("train_busy", 64'(busy_seen[3]), 64'(38));
    check_val("train_done", 64'(done_seen[3]), 64'(1));

    clr_seen();
    issue(4, 0, 3, 5);
    issue(6, 7, 3, 0);
    idle(4);
    check_val("w0_busy", 64'(busy_seen[4]), 64'(1));
    check_val("w0_done", 64'(done_seen[4]), 64'(1));
    check_val("n0_busy", 64'(busy_seen[6]), 64'(1));
    check_val("n0_pulse", 64'(pulse_seen[6]), 64'(0));

    clr_seen();
    issue(7, 3, 0, 2);
    idle(10);
    check_val("gap0_high", 64'(pulse_seen[7]), 64'(6));
    check_val("gap0_busy", 64'(busy_seen[7]), 64'(7));

    clr_seen();
    issue(1, 20, 2, 2);
    issue(31, 15, 3, 3);
    issue(1, 5, 1, 1);
    idle(60);
    check_val("bp_busy1", 64'(busy_seen[1]), 64'(47));
    check_val("bp_done1", 64'(done_seen[1]), 64'(2));
    check_val("ovl_busy31", 64'(busy_seen[31]), 64'(51));
    check_val("ovl_high31", 64'(pulse_seen[31]), 64'(45));

    for (int c = 32; c < 40; c++) step(1'b1, c, 5, 1, 1, acc);
    step(1'b1, 63, 5, 1, 1, acc);
    idle(3);

    repeat (3000) begin
      ch = $urandom_range(0, 39);
      step(($urandom_range(0, 1) == 1), ch, $urandom_range(0, 12), $urandom_range(0, 5),
           $urandom_range(0, 4), acc);
    end
    idle(80);

    clr_seen();
    issue(5, 2000000, 1, 1);
    idle(30);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_async_pulse", 64'(pulse_out), 64'(0));
    check_val("rst_async_busy", 64'(busy), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr_seen();
    idle(10);
    check_val("rst_no_done", 64'(done_seen[5]), 64'(0));
    issue(5, 6, 2, 2);
    idle(20);
    check_val("rst_after_high", 64'(pulse_seen[5]), 64'(12));
    check_val("rst_after_done", 64'(done_seen[5]), 64'(1));

`ifdef PULSE_GEN_ABORT_EN
    clr_seen();
    issue(2, 20, 3, 1);
    idle(4);
    ab_req[2] = 1'b1;
    idle(1);
    ab_req = '0;
    idle(5);
    check_val("abort_high", 64'(pulse_seen[2]), 64'(5));
    check_val("abort_done", 64'(done_seen[2]), 64'(1));
    ab_req[9] = 1'b1;
    idle(1);
    ab_req = '0;
    idle(3);
    check_val("abort_idle_done", 64'(done_seen[9]), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
